// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
package seg7_pkg;

  // Segment pattern {a,b,c,d,e,f,g} for a dark digit (active-high).
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int dig_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Code -> segment table. Without hex, 10-14 fall back to '0' and 15 is dark.
  function automatic logic [6:0] seg_of(input logic [3:0] code, input logic hex_en);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = hex_en ? 7'b1110111 : 7'b1111110;
      4'hB:    s = hex_en ? 7'b0011111 : 7'b1111110;
      4'hC:    s = hex_en ? 7'b1001110 : 7'b1111110;
      4'hD:    s = hex_en ? 7'b0111101 : 7'b1111110;
      4'hE:    s = hex_en ? 7'b1001111 : 7'b1111110;
      default: s = hex_en ? 7'b1000111 : SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-high segment decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  output logic [6:0] seg
);

  // Pure table lookup; blanking decisions live in the scan controller.
  always_comb begin
    seg = seg_of(code, hex_en);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit scan, frame-latched
// inputs, leading-zero suppression, per-digit blink, brightness PWM, and
// output polarity selection applied only at the output registers.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIG      = 4,
  parameter int DIV_W        = 16,
  parameter int BR_W         = 3,
  parameter int BLINK_FRAMES = 96,
  parameter bit HEX_EN       = 1'b0,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit SCAN_ACT_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 disp_en,
  input  logic [4*NUM_DIG-1:0] digits,
  input  logic [NUM_DIG-1:0]   dp_in,
  input  logic [NUM_DIG-1:0]   blink_mask,
  input  logic                 lz_en,
  input  logic [BR_W-1:0]      brightness,
  output logic [NUM_DIG-1:0]   scan,
  output logic [6:0]           display,
  output logic                 dp,
  output logic                 frame_tick
);

  localparam int                 DIG_W    = dig_w(NUM_DIG);
  localparam int                 BLK_W    = dig_w(BLINK_FRAMES);
  localparam logic [DIG_W-1:0]   IDX_MAX  = DIG_W'(NUM_DIG - 1);
  localparam logic [BLK_W-1:0]   BLK_MAX  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIG-1:0] SCAN_OFF = {NUM_DIG{SCAN_ACT_LOW}};
  localparam logic [6:0]         SEG_OFF  = {7{SEG_ACT_LOW}};

  logic [DIV_W-1:0]     pre_q, pre_d;
  logic [DIG_W-1:0]     idx_q, idx_d;
  logic [BLK_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                 blink_on_q, blink_on_d;
  logic [4*NUM_DIG-1:0] digits_s_q, digits_s_d;
  logic [NUM_DIG-1:0]   dp_s_q, dp_s_d;
  logic [NUM_DIG-1:0]   blink_s_q, blink_s_d;
  logic                 lz_s_q, lz_s_d;
  logic [NUM_DIG-1:0]   scan_q, scan_d;
  logic [6:0]           display_q, display_d;
  logic                 dp_q, dp_d;
  logic                 frame_tick_q, frame_tick_d;

  logic                 slot_end, frame_end;
  logic [3:0]           code;
  logic [6:0]           seg_dec;
  logic                 lz_blank, blank, lit, dp_act;
  logic [NUM_DIG-1:0]   scan_act;
  logic [6:0]           seg_act;

  seg7_decode u_decode (
    .code   (code),
    .hex_en (HEX_EN),
    .seg    (seg_dec)
  );

  // Timebase: prescaler, MSD-first digit index, frame-boundary shadow latch and blink phase.
  always_comb begin
    slot_end     = &pre_q;
    frame_end    = slot_end && (idx_q == '0);
    pre_d        = pre_q + 1'b1;
    idx_d        = idx_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    digits_s_d   = digits_s_q;
    dp_s_d       = dp_s_q;
    blink_s_d    = blink_s_q;
    lz_s_d       = lz_s_q;
    frame_tick_d = frame_end;
    if (slot_end) begin
      idx_d = (idx_q == '0) ? IDX_MAX : idx_q - 1'b1;
    end
    if (frame_end) begin
      // Inputs become visible only at the start of a frame, so a frame never tears.
      digits_s_d = digits;
      dp_s_d     = dp_in;
      blink_s_d  = blink_mask;
      lz_s_d     = lz_en;
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Current-digit blanking, PWM gating and polarity of the next output word.
  always_comb begin
    code     = digits_s_q[{idx_q, 2'b00} +: 4];
    // A digit is a leading zero when it and every more-significant digit are zero.
    lz_blank = lz_s_q && (idx_q != '0);
    for (int j = 0; j < NUM_DIG; j++) begin
      if ((DIG_W'(j) >= idx_q) && (digits_s_q[4*j +: 4] != 4'd0)) begin
        lz_blank = 1'b0;
      end
    end
    blank    = !disp_en || (blink_s_q[idx_q] && !blink_on_q) || lz_blank ||
               (!HEX_EN && (code == 4'hF));
    // Top prescaler bits act as the PWM ramp; the unlit tail guards against ghosting.
    lit      = pre_q[DIV_W-1 -: BR_W] < brightness;
    scan_act = '0;
    if (lit) begin
      scan_act[idx_q] = 1'b1;
    end
    seg_act   = blank ? SEG_BLANK : seg_dec;
    dp_act    = !blank && dp_s_q[idx_q];
    scan_d    = scan_act ^ SCAN_OFF;
    display_d = seg_act ^ SEG_OFF;
    dp_d      = dp_act ^ SEG_ACT_LOW;
  end

  // State and output registers; reset darkens the panel on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q        <= '0;
      idx_q        <= IDX_MAX;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      digits_s_q   <= '0;
      dp_s_q       <= '0;
      blink_s_q    <= '0;
      lz_s_q       <= 1'b0;
      scan_q       <= SCAN_OFF;
      display_q    <= SEG_OFF;
      dp_q         <= SEG_ACT_LOW;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      digits_s_q   <= digits_s_d;
      dp_s_q       <= dp_s_d;
      blink_s_q    <= blink_s_d;
      lz_s_q       <= lz_s_d;
      scan_q       <= scan_d;
      display_q    <= display_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign scan       = scan_q;
  assign display    = display_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomised bench for seg7_scan_ctrl: a default-polarity decimal instance and
// a hex, fully inverted instance share stimulus and are compared every cycle
// against a cycle-count based model of the display.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BW = 2;
  localparam int BF = 2;
  localparam int SLOT  = 1 << DW;
  localparam int FRAME = SLOT * ND;

  logic        clk = 1'b0;
  logic        reset, disp_en, lz_en;
  logic [15:0] digits;
  logic [3:0]  dp_in, blink_mask;
  logic [1:0]  brightness;

  logic [3:0]  scan_a, scan_b;
  logic [6:0]  disp_a, disp_b;
  logic        dp_a, dp_b, ft_a, ft_b;

  int n_chk = 0;
  int n_err = 0;

  // Model state: cycles since reset release and the frame-latched inputs.
  int          c = 0;
  logic [15:0] dig_s = '0;
  logic [3:0]  dp_s = '0, bm_s = '0;
  logic        lz_s = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIG(ND), .DIV_W(DW), .BR_W(BW), .BLINK_FRAMES(BF),
    .HEX_EN(1'b0), .SEG_ACT_LOW(1'b0), .SCAN_ACT_LOW(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .disp_en(disp_en), .digits(digits),
    .dp_in(dp_in), .blink_mask(blink_mask), .lz_en(lz_en),
    .brightness(brightness), .scan(scan_a), .display(disp_a),
    .dp(dp_a), .frame_tick(ft_a)
  );

  seg7_scan_ctrl #(
    .NUM_DIG(ND), .DIV_W(DW), .BR_W(BW), .BLINK_FRAMES(BF),
    .HEX_EN(1'b1), .SEG_ACT_LOW(1'b1), .SCAN_ACT_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .disp_en(disp_en), .digits(digits),
    .dp_in(dp_in), .blink_mask(blink_mask), .lz_en(lz_en),
    .brightness(brightness), .scan(scan_b), .display(disp_b),
    .dp(dp_b), .frame_tick(ft_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Expected active-high outputs for the current cycle count and live inputs.
  function automatic void model(input bit hex, output logic [3:0] sc,
                                output logic [6:0] sg, output logic d);
    int   p, k, f;
    bit   blink_on, lzb, blank;
    logic [3:0] code;
    p        = c % SLOT;
    k        = ND - 1 - ((c / SLOT) % ND);
    f        = c / FRAME;
    blink_on = ((f / BF) % 2) == 0;
    code     = dig_s[4*k +: 4];
    lzb      = lz_s && (k != 0);
    for (int j = k; j < ND; j++) begin
      if (dig_s[4*j +: 4] != 4'd0) lzb = 1'b0;
    end
    blank = !disp_en || (bm_s[k] && !blink_on) || lzb || (!hex && code == 4'hF);
    if (blank)                 sg = 7'b0;
    else if (hex || code < 10) sg = seg_tab[code];
    else                       sg = seg_tab[0];
    d  = !blank && dp_s[k];
    sc = ((p / (SLOT >> BW)) < int'(brightness)) ? 4'(1 << k) : 4'b0;
  endfunction

  task automatic cycle();
    logic [3:0] sa, sb;
    logic [6:0] ga, gb;
    logic       da, db, ft;
    if (reset) begin
      sa = 4'h0; ga = 7'h00; da = 1'b0;
      sb = 4'hF; gb = 7'h7F; db = 1'b1;
      ft = 1'b0;
    end else begin
      model(1'b0, sa, ga, da);
      model(1'b1, sb, gb, db);
      sb = ~sb; gb = ~gb; db = ~db;
      ft = (c % FRAME) == FRAME - 1;
    end
    @(posedge clk);
    #1;
    check("scan_a",  32'(scan_a), 32'(sa));
    check("disp_a",  32'(disp_a), 32'(ga));
    check("dp_a",    32'(dp_a),   32'(da));
    check("tick_a",  32'(ft_a),   32'(ft));
    check("scan_b",  32'(scan_b), 32'(sb));
    check("disp_b",  32'(disp_b), 32'(gb));
    check("dp_b",    32'(dp_b),   32'(db));
    check("tick_b",  32'(ft_b),   32'(ft));
    if (reset) begin
      c = 0; dig_s = '0; dp_s = '0; bm_s = '0; lz_s = 1'b0;
    end else begin
      if ((c % FRAME) == FRAME - 1) begin
        dig_s = digits; dp_s = dp_in; bm_s = blink_mask; lz_s = lz_en;
      end
      c++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    reset = 1'b1; disp_en = 1'b1; lz_en = 1'b0; digits = '0;
    dp_in = '0; blink_mask = '0; brightness = 2'd3;
    run(3);
    reset = 1'b0;
    run(FRAME);

    digits = 16'h1234;
    run(3 * FRAME);

    digits = 16'h0050; lz_en = 1'b1; dp_in = 4'b0010;
    run(3 * FRAME);

    blink_mask = 4'b0001; lz_en = 1'b0;
    run(6 * FRAME);
    blink_mask = 4'b0000;

    brightness = 2'd1;
    run(2 * FRAME);
    brightness = 2'd0;
    run(FRAME);
    brightness = 2'd3;

    digits = 16'hABCF;
    run(2 * FRAME);
    disp_en = 1'b0;
    run(FRAME / 2);
    disp_en = 1'b1;
    run(FRAME / 2 + 20);

    // Mid-frame change stays hidden until the boundary; reset lands mid-slot.
    digits = 16'h9876;
    run(30);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(2 * FRAME);

    for (int i = 0; i < 40; i++) begin
      digits     = 16'($urandom);
      dp_in      = 4'($urandom);
      blink_mask = 4'($urandom);
      lz_en      = 1'($urandom);
      disp_en    = ($urandom_range(0, 7) != 0);
      brightness = 2'($urandom);
      reset      = ($urandom_range(0, 15) == 0);
      if (reset) begin
        run(1 + $urandom_range(0, 2));
        reset = 1'b0;
      end
      run($urandom_range(1, 150));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
